// File: rtl/fb_fill_writer.sv
// Rectangle-fill write engine for the pixel frame buffer.
// Accepts (x, y, w, h, color) commands over valid/ready, clips them to the
// frame and writes one byte-wide pixel per clock through the BRAM port.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_x/y/w/h, cmd_color           rectangle and {R,G,B} pixel value
//   busy, done                       command in progress / 1-cycle finish pulse
//   buffer_addr/din/en/rst/we        BRAM write port (byte address = pixel index)
module fb_fill_writer #(
  parameter int unsigned FB_WIDTH         = 400,
  parameter int unsigned FB_HEIGHT        = 300,
  parameter int unsigned X_BITS           = 9,
  parameter int unsigned Y_BITS           = 9,
  parameter int unsigned BUFFER_ADDR_BITS = 17,
  parameter int unsigned CHANNEL_BITS     = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [X_BITS-1:0]         cmd_x,
  input  logic [Y_BITS-1:0]         cmd_y,
  input  logic [X_BITS-1:0]         cmd_w,
  input  logic [Y_BITS-1:0]         cmd_h,
  input  logic [3*CHANNEL_BITS-1:0] cmd_color,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               buffer_addr,
  output logic [31:0]               buffer_din,
  output logic                      buffer_en,
  output logic                      buffer_rst,
  output logic [3:0]                buffer_we
);

  localparam int unsigned AW = BUFFER_ADDR_BITS;
  localparam int unsigned CW = 3 * CHANNEL_BITS;

  localparam logic [X_BITS:0] FBW_X = (X_BITS + 1)'(FB_WIDTH);
  localparam logic [Y_BITS:0] FBH_Y = (Y_BITS + 1)'(FB_HEIGHT);
  localparam logic [AW-1:0]   FBW_A = AW'(FB_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLIP = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d, w_q, w_d;
  logic [Y_BITS-1:0] y_q, y_d, h_q, h_d;
  logic [CW-1:0]     color_q, color_d;
  logic [X_BITS:0]   col_q, col_d;
  logic [Y_BITS:0]   row_q, row_d;
  logic [AW-1:0]     row_base_q, row_base_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       din_d;
  logic [3:0]        we_d;
  logic              en_d, ready_d, busy_d, done_d;

  logic [X_BITS:0]   x_sum_c, x_end_c;
  logic [Y_BITS:0]   y_sum_c, y_end_c;
  logic [AW-1:0]     row_base_c;
  logic              empty_c, row_end_c, last_c;

  // Clip window: sums carry one extra bit so x+w / y+h never wrap.
  always_comb begin
    x_sum_c    = {1'b0, x_q} + {1'b0, w_q};
    y_sum_c    = {1'b0, y_q} + {1'b0, h_q};
    x_end_c    = (x_sum_c > FBW_X) ? FBW_X : x_sum_c;
    y_end_c    = (y_sum_c > FBH_Y) ? FBH_Y : y_sum_c;
    empty_c    = ({1'b0, x_q} >= FBW_X) || ({1'b0, y_q} >= FBH_Y) ||
                 (w_q == '0) || (h_q == '0);
    row_base_c = AW'(y_q) * FBW_A;
    row_end_c  = (col_q + 1'b1) == x_end_c;
    last_c     = row_end_c && ((row_q + 1'b1) == y_end_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    din_d      = buffer_din;
    en_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        if (empty_c) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_FILL;
          col_d      = {1'b0, x_q};
          row_d      = {1'b0, y_q};
          row_base_d = row_base_c;
          addr_d     = row_base_c + AW'(x_q);
          din_d      = {4{8'(color_q)}};
          en_d       = 1'b1;
        end
      end
      S_FILL: begin
        if (last_c) begin
          state_d = S_DONE;
        end else if (row_end_c) begin
          // Wrap to the next row; the row base only ever advances by addition.
          col_d      = {1'b0, x_q};
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + FBW_A;
          addr_d     = row_base_q + FBW_A + AW'(x_q);
          en_d       = 1'b1;
        end else begin
          col_d  = col_q + 1'b1;
          addr_d = addr_q + 1'b1;
          en_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One byte lane per pixel, selected by the low address bits.
    we_d    = en_d ? 4'(4'b0001 << addr_d[1:0]) : 4'b0000;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      buffer_din <= '0;
      buffer_en  <= 1'b0;
      buffer_we  <= 4'b0000;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      buffer_din <= din_d;
      buffer_en  <= en_d;
      buffer_we  <= we_d;
      cmd_ready  <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign buffer_addr = 32'(addr_q);
  assign buffer_rst  = 1'b0;

endmodule

// File: doc/fb_fill_writer.md
Name: fb_fill_writer

Overview:
- Write-side engine for the pixel frame buffer; the display scan-out path is the read side of the same buffer.
- Accepts rectangle-fill commands (x, y, w, h, color) over a valid/ready handshake.
- Clips each rectangle to the frame and writes it one pixel per clock through the frame buffer's BRAM port.
- Byte-addressed, byte-per-pixel layout identical to the scan-out read path.

Parameters:
- FB_WIDTH, 400, frame width in pixels (visible width / downscale factor)
- FB_HEIGHT, 300, frame height in pixels
- X_BITS, 9, width of x/w command fields
- Y_BITS, 9, width of y/h command fields
- BUFFER_ADDR_BITS, 17, significant bits of buffer_addr; bits above are zero
- CHANNEL_BITS, 2, bits per color channel; a pixel is 3*CHANNEL_BITS bits

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  X_BITS  left column
- cmd_y  in  Y_BITS  top row
- cmd_w  in  X_BITS  width in pixels
- cmd_h  in  Y_BITS  height in pixels
- cmd_color  in  3*CHANNEL_BITS  pixel value {R,G,B}
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command finishes
- buffer_addr  out  32  byte address = pixel index
- buffer_din  out  32  write data
- buffer_en  out  1  BRAM enable
- buffer_rst  out  1  BRAM reset, tied 0
- buffer_we  out  4  byte write enables

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; cmd_ready=1; busy=0; done=0.
  - buffer_en=0, buffer_we=0, buffer_addr=0, buffer_din=0.
  - All registered outputs change immediately on reset assertion.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd fields, go to CLIP.
  - CLIP (1 cycle), with x_end = min(x+w, FB_WIDTH) and y_end = min(y+h, FB_HEIGHT), computed at X_BITS+1 / Y_BITS+1 bits so there is no overflow:
    - Empty command (x>=FB_WIDTH, y>=FB_HEIGHT, w==0 or h==0): go to DONE.
    - Otherwise: set row_base = y*FB_WIDTH, col = x, go to FILL.
  - FILL: one write per cycle.
    - Write fields: buffer_addr = row_base+col; buffer_en=1; buffer_we = 4'b0001 << buffer_addr[1:0]; buffer_din = {4{8'(cmd_color)}} (color zero-extended into each byte).
    - After each write: col+1. When col+1==x_end: col=x, row_base += FB_WIDTH, row+1.
    - When the last pixel (row==y_end-1 and col==x_end-1) is written, go to DONE.
    - Row-major order: left→right, top→bottom.
  - DONE (1 cycle): done=1, buffer_en=0, buffer_we=0. Next state IDLE.
- Output levels by state:
  - busy=1 in CLIP/FILL/DONE.
  - cmd_ready=1 only in IDLE; no command is accepted while busy.
  - cmd_valid held across busy is accepted on the first IDLE cycle.
- Timing:
  - Accept at cycle N; CLIP at N+1; first write at N+2.
  - A k-pixel write finishes at N+1+k; done at N+2+k.
  - Empty command: done at N+2.
  - Back-to-back throughput: k+3 cycles per command.
- No multiplier in FILL: row_base is advanced only by addition. The single y*FB_WIDTH product in CLIP is permitted.
- Reset mid-FILL: the write is abandoned immediately, with no done pulse; the buffer contents already written remain.
- buffer_rst is constant 0. buffer_addr bits [31:BUFFER_ADDR_BITS] are always 0.

Test Plan:
- Single pixel: x=3,y=0,w=1,h=1,color=6'h2A.
  - Exactly one write: addr=3, we=4'b1000, din=32'h2A2A2A2A, at accept+2.
  - done at accept+3.
- Bottom-right clip: x=398,y=299,w=4,h=4,color=6'h15.
  - Exactly two writes: addr 119998 (we 4'b0100), then 119999 (we 4'b1000).
  - No writes beyond 119999.
- Empty commands (each case in turn: w=0; x=400; y=300).
  - buffer_we never nonzero.
  - done pulses at accept+2; busy is high for 2 cycles.
- Row wrap: x=10,y=5,w=3,h=2.
  - Write sequence: 2010, 2011, 2012, 2410, 2411, 2412, consecutive cycles.
  - done one cycle after 2412.
- Backpressure / back-to-back: cmd_valid held high with two queued commands.
  - cmd_ready is low throughout the first command's busy period.
  - The second command is accepted in the IDLE cycle after done.
- Reset mid-fill: full-frame clear (0,0,400,300), with resetn pulsed low after 1000 writes.
  - Outputs go to reset values immediately; no done pulse.
  - cmd_ready=1 after release.
